gray_ptr_xdom: RTL and testbench

//  Parametrised Gray-code pointer block for clock-domain crossings (async FIFO pointers, frame counters).

---
 rtl/gray_ptr_xdom.sv | 181 ++++++++++++++++++
 tb/tb_gray_ptr_xdom.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_xdom.sv
// gray_ptr_xdom
// Gray-code pointer block for clock-domain crossings.
// Local side: an up/down/loadable binary counter that carries a registered
// Gray copy. The Gray copy is updated in the same cycle as the binary value,
// so another domain can sample it safely.
// Remote side: synchronises a Gray pointer from another domain and decodes
// it to binary. It also flags any multi-bit step between consecutive
// synchronised samples.

module gray_ptr_xdom #(
  parameter int SZ_DATA     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DECODE_PIPE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [SZ_DATA-1:0] load_bin,
  output logic [SZ_DATA-1:0] cnt_bin,
  output logic [SZ_DATA-1:0] cnt_gray,
  output logic               wrap,
  input  logic [SZ_DATA-1:0] remote_gray,
  output logic [SZ_DATA-1:0] remote_bin,
  output logic               remote_valid,
  output logic               remote_err
);

  // Number of edges after reset release before the remote history is real
  // data. The last sync stage must be filled, then the history register
  // must capture that value, then the optional decode register must load.
  localparam int FILL = SYNC_STAGES + 1 + DECODE_PIPE;
  localparam int FW   = $clog2(FILL + 1);

  // Binary-to-Gray conversion.
  function automatic logic [SZ_DATA-1:0] to_gray(input logic [SZ_DATA-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray-to-binary conversion. Each binary bit is the XOR of every Gray bit
  // at or above its position.
  function automatic logic [SZ_DATA-1:0] from_gray(input logic [SZ_DATA-1:0] g);
    logic [SZ_DATA-1:0] b;
    b[SZ_DATA-1] = g[SZ_DATA-1];
    for (int n = SZ_DATA - 2; n >= 0; n--) begin
      b[n] = g[n] ^ b[n+1];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // Local counter
  // ---------------------------------------------------------------------

  logic [SZ_DATA-1:0] cnt_next;
  logic               wrap_next;

  // Next-count selection. Load has priority over enable. The wrap flag
  // marks a step that crosses the modulus boundary in either direction.
  always_comb begin
    cnt_next  = cnt_bin;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = load_bin;
    end else if (en) begin
      if (dir) begin
        cnt_next  = cnt_bin + SZ_DATA'(1);
        wrap_next = (cnt_bin == {SZ_DATA{1'b1}});
      end else begin
        cnt_next  = cnt_bin - SZ_DATA'(1);
        wrap_next = (cnt_bin == '0);
      end
    end
  end

  // Register the binary and Gray forms together. The Gray form is derived
  // from the next value, so it never lags the binary form by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_bin  <= '0;
      cnt_gray <= '0;
      wrap     <= 1'b0;
    end else begin
      cnt_bin  <= cnt_next;
      cnt_gray <= to_gray(cnt_next);
      wrap     <= wrap_next;
    end
  end

  // ---------------------------------------------------------------------
  // Remote pointer path
  // ---------------------------------------------------------------------

  logic [SZ_DATA-1:0] sync_q [SYNC_STAGES];
  logic [SZ_DATA-1:0] s;
  logic [SZ_DATA-1:0] h;
  logic [SZ_DATA-1:0] s_bin;
  logic [SZ_DATA-1:0] diff;
  logic               err_raw;
  logic               err_aligned;
  logic [FW-1:0]      fill_cnt;

  // Synchroniser chain for the asynchronous Gray pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Previous synchronised sample, used to detect illegal multi-bit steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
    end else begin
      h <= s;
    end
  end

  // A legal Gray step changes at most one bit. Clearing the lowest set bit
  // of the difference leaves a nonzero value only when two or more bits
  // changed.
  always_comb begin
    s_bin   = from_gray(s);
    diff    = s ^ h;
    err_raw = (diff & (diff - SZ_DATA'(1))) != '0;
  end

  generate
    if (DECODE_PIPE == 0) begin : g_decode_comb
      assign remote_bin  = s_bin;
      assign err_aligned = err_raw;
    end else begin : g_decode_pipe
      logic [SZ_DATA-1:0] bin_q;
      logic               err_q;

      // Extra output register on the decoded value. The error flag is
      // delayed by the same amount so it stays aligned with remote_bin.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bin_q <= '0;
          err_q <= 1'b0;
        end else begin
          bin_q <= s_bin;
          err_q <= err_raw;
        end
      end

      assign remote_bin  = bin_q;
      assign err_aligned = err_q;
    end
  endgenerate

  // Fill counter. It holds remote_valid low until the synchroniser, the
  // history register and the decode register all carry post-reset data.
  // Without it, a nonzero remote pointer at reset release would look like
  // an illegal jump from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt     <= '0;
      remote_valid <= 1'b0;
    end else if (!remote_valid) begin
      fill_cnt <= fill_cnt + FW'(1);
      if (fill_cnt == FW'(FILL - 1)) begin
        remote_valid <= 1'b1;
      end
    end
  end

  assign remote_err = err_aligned & remote_valid;

endmodule

// File: tb/tb_gray_ptr_xdom.sv
// tb_gray_ptr_xdom
// Directed bench for gray_ptr_xdom. One instance uses a combinational decode
// and a second uses a registered decode. Both share every input, so the
// remote-path latencies can be compared side by side.

module tb_gray_ptr_xdom;

  localparam int W = 4;

  // Hand-computed Gray codes for 0..15.
  localparam logic [3:0] GRAY_TBL [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] remote_gray;

  logic [W-1:0] cnt_bin0, cnt_gray0, remote_bin0;
  logic         wrap0, remote_valid0, remote_err0;
  logic [W-1:0] cnt_bin1, cnt_gray1, remote_bin1;
  logic         wrap1, remote_valid1, remote_err1;

  int compared   = 0;
  int mismatched = 0;

  gray_ptr_xdom #(.SZ_DATA(W), .SYNC_STAGES(2), .DECODE_PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .cnt_bin(cnt_bin0), .cnt_gray(cnt_gray0), .wrap(wrap0),
    .remote_gray(remote_gray), .remote_bin(remote_bin0),
    .remote_valid(remote_valid0), .remote_err(remote_err0)
  );

  gray_ptr_xdom #(.SZ_DATA(W), .SYNC_STAGES(2), .DECODE_PIPE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .cnt_bin(cnt_bin1), .cnt_gray(cnt_gray1), .wrap(wrap1),
    .remote_gray(remote_gray), .remote_bin(remote_bin1),
    .remote_valid(remote_valid1), .remote_err(remote_err1)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [W-1:0] b, input logic [W-1:0] g, input logic w);
    chk({tag, " cnt_bin"}, 32'(cnt_bin0), 32'(b));
    chk({tag, " cnt_gray"}, 32'(cnt_gray0), 32'(g));
    chk({tag, " wrap"}, 32'(wrap0), 32'(w));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_bin = '0;
    remote_gray = 4'b1100;

    // Reset state
    #2;
    chk_cnt("reset", 4'h0, 4'h0, 1'b0);
    chk("reset remote_bin0", 32'(remote_bin0), 32'h0);
    chk("reset remote_valid0", 32'(remote_valid0), 32'h0);
    chk("reset remote_err0", 32'(remote_err0), 32'h0);
    chk("reset remote_bin1", 32'(remote_bin1), 32'h0);
    chk("reset remote_valid1", 32'(remote_valid1), 32'h0);
    #1 rst = 1'b0;

    // Remote fill: 1100 decodes to 8
    step();
    chk("fill e1 bin0", 32'(remote_bin0), 32'h0);
    chk("fill e1 valid0", 32'(remote_valid0), 32'h0);
    step();
    chk("fill e2 bin0", 32'(remote_bin0), 32'h8);
    chk("fill e2 valid0", 32'(remote_valid0), 32'h0);
    chk("fill e2 err0", 32'(remote_err0), 32'h0);
    chk("fill e2 bin1", 32'(remote_bin1), 32'h0);
    step();
    chk("fill e3 valid0", 32'(remote_valid0), 32'h1);
    chk("fill e3 err0", 32'(remote_err0), 32'h0);
    chk("fill e3 bin0", 32'(remote_bin0), 32'h8);
    chk("fill e3 bin1", 32'(remote_bin1), 32'h8);
    chk("fill e3 valid1", 32'(remote_valid1), 32'h0);
    chk("fill e3 err1", 32'(remote_err1), 32'h0);
    step();
    chk("fill e4 valid1", 32'(remote_valid1), 32'h1);
    chk("fill e4 err1", 32'(remote_err1), 32'h0);
    chk("fill e4 err0", 32'(remote_err0), 32'h0);

    // Count up for 17 cycles; the remote pointer moves to 0110 meanwhile
    remote_gray = 4'b0110;
    en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk_cnt($sformatf("up%0d", k), 4'(k), GRAY_TBL[k % 16], k == 16);
    end
    chk("up cnt_gray1", 32'(cnt_gray1), 32'h1);

    // Count down through zero
    en = 1'b0; load = 1'b1; load_bin = 4'h0;
    step();
    chk_cnt("load0", 4'h0, 4'h0, 1'b0);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    step();
    chk_cnt("down0", 4'hF, 4'h8, 1'b1);
    step();
    chk_cnt("down1", 4'hE, 4'h9, 1'b0);

    // Load beats enable, then counting resumes from the loaded value
    load = 1'b1; load_bin = 4'hA;
    step();
    chk_cnt("loadA", 4'hA, 4'hF, 1'b0);
    load = 1'b0; dir = 1'b1;
    step();
    chk_cnt("afterA", 4'hB, 4'hE, 1'b0);
    load = 1'b1; load_bin = 4'hF;
    step();
    chk_cnt("loadF", 4'hF, 4'h8, 1'b0);
    load = 1'b0;
    step();
    chk_cnt("wrapF", 4'h0, 4'h0, 1'b1);

    // Illegal two-bit step 0110 -> 0101
    en = 1'b0;
    chk("pre bin0", 32'(remote_bin0), 32'h4);
    remote_gray = 4'b0101;
    step();
    chk("bad e1 err0", 32'(remote_err0), 32'h0);
    step();
    chk("bad e2 err0", 32'(remote_err0), 32'h1);
    chk("bad e2 bin0", 32'(remote_bin0), 32'h6);
    chk("bad e2 err1", 32'(remote_err1), 32'h0);
    chk("bad e2 bin1", 32'(remote_bin1), 32'h4);
    step();
    chk("bad e3 err0", 32'(remote_err0), 32'h0);
    chk("bad e3 err1", 32'(remote_err1), 32'h1);
    chk("bad e3 bin1", 32'(remote_bin1), 32'h6);
    step();
    chk("bad e4 err1", 32'(remote_err1), 32'h0);

    // Asynchronous reset while counting
    load = 1'b1; load_bin = 4'h7;
    step();
    chk_cnt("load7", 4'h7, 4'h4, 1'b0);
    load = 1'b0; en = 1'b1;
    rst = 1'b1;
    #1;
    chk_cnt("midrst", 4'h0, 4'h0, 1'b0);
    chk("midrst bin0", 32'(remote_bin0), 32'h0);
    chk("midrst valid0", 32'(remote_valid0), 32'h0);
    chk("midrst bin1", 32'(remote_bin1), 32'h0);
    chk("midrst valid1", 32'(remote_valid1), 32'h0);
    chk("midrst gray1", 32'(cnt_gray1), 32'h0);
    en = 1'b0;
    #2 rst = 1'b0;
    step();
    chk("refill e1 valid0", 32'(remote_valid0), 32'h0);
    step();
    chk("refill e2 valid0", 32'(remote_valid0), 32'h0);
    chk("refill e2 bin0", 32'(remote_bin0), 32'h6);
    step();
    chk("refill e3 valid0", 32'(remote_valid0), 32'h1);
    chk("refill e3 err0", 32'(remote_err0), 32'h0);
    chk("refill e3 valid1", 32'(remote_valid1), 32'h0);
    chk("refill e3 bin1", 32'(remote_bin1), 32'h6);
    step();
    chk("refill e4 valid1", 32'(remote_valid1), 32'h1);
    chk("refill e4 err1", 32'(remote_err1), 32'h0);
    chk_cnt("refill", 4'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
